// File: rtl/muldiv_seq_unit.sv
`timescale 1ns/1ps
// muldiv_seq_unit
//   Multi-cycle sequencer for the RV64 M-extension ops: radix-2 shift-add
//   multiply and restoring divide, one bit per cycle. Special cases
//   (divide by zero, signed overflow, non-existent W high-multiplies)
//   bypass the iteration loop.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start_i   issue request, sampled only in IDLE
//   op_i      funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   word_i    32-bit *W variant, result sign-extended
//   rs1_i     operand A / dividend
//   rs2_i     operand B / divisor
//   rd_i      destination tag
//   flush_i   kill the in-flight op
//   busy_o    high while not IDLE
//   done_o    one-cycle completion pulse
//   result_o  result, held until the next completion
//   rd_o      tag of the completed op
//
// State | meaning
//   IDLE  | waiting for start_i
//   CALC  | one multiply/divide iteration per cycle
//   FIXUP | sign correction / result select
//   DONE  | done_o pulse, result valid
module muldiv_seq_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic            word_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            fast_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier+product low half / dividend+quotient
  logic [XLEN-1:0] b_q;       // multiplicand / divisor magnitude
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;
  logic            done_q;

  // ---------------- accept-time operand conditioning ----------------
  logic            sgn_a_op, sgn_b_op;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_ext, fast_res_d;
  logic            sa, sb, neg_d, div_zero, ovf, w_bad, fast_d;

  always_comb begin
    sgn_a_op = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sgn_b_op = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);

    if (word_i) begin
      a_ext   = sgn_a_op ? {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]} : {{(XLEN-32){1'b0}}, rs1_i[31:0]};
      b_ext   = sgn_b_op ? {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]} : {{(XLEN-32){1'b0}}, rs2_i[31:0]};
      min_ext = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext   = rs1_i;
      b_ext   = rs2_i;
      min_ext = {1'b1, {(XLEN-1){1'b0}}};
    end

    sa    = sgn_a_op & a_ext[XLEN-1];
    sb    = sgn_b_op & b_ext[XLEN-1];
    mag_a = sa ? -a_ext : a_ext;
    mag_b = sb ? -b_ext : b_ext;

    // REM/REMU take the dividend's sign; everything else takes sA ^ sB.
    neg_d = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);

    div_zero = op_i[2] & (b_ext == '0);
    ovf      = op_i[2] & ~op_i[0] & (a_ext == min_ext) & (b_ext == '1);
    w_bad    = word_i & ~op_i[2] & (op_i[1:0] != 2'b00);
    fast_d   = div_zero | ovf | w_bad;

    // Fast-path result is parked in lo_q until FIXUP.
    fast_res_d = '0;
    if (w_bad)
      fast_res_d = '0;
    else if (div_zero)
      fast_res_d = op_i[1] ? (word_i ? {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]} : rs1_i) : '1;
    else if (ovf)
      fast_res_d = op_i[1] ? '0 : min_ext;
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] mul_acc_d, mul_lo_d, div_acc_d, div_lo_d, div_sub;
  logic            div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_acc_d = mul_sum[XLEN:1];
    mul_lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};

    div_sh    = {acc_q, lo_q[XLEN-1]};
    div_ge    = div_sh >= {1'b0, b_q};
    // When div_ge holds the true difference is below b_q, so XLEN bits suffice.
    div_sub   = div_sh[XLEN-1:0] - b_q;
    div_acc_d = div_ge ? div_sub : div_sh[XLEN-1:0];
    div_lo_d  = {lo_q[XLEN-2:0], div_ge};
  end

  // ---------------- fixup ----------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, q_raw, r_raw, div_sel, div_sel_s, div_res, fix_res;

  always_comb begin
    prod   = {acc_q, lo_q};
    prod_s = neg_q ? -prod : prod;

    // After 32 iterations the W product's low word has been shifted into lo_q[63:32].
    if (word_q)
      mul_res = {{(XLEN-32){lo_q[XLEN-1]}}, lo_q[XLEN-1 -: 32]};
    else if (op_q[1:0] == 2'b00)
      mul_res = prod_s[XLEN-1:0];
    else
      mul_res = prod_s[2*XLEN-1:XLEN];

    q_raw     = word_q ? {{(XLEN-32){1'b0}}, lo_q[31:0]}  : lo_q;
    r_raw     = word_q ? {{(XLEN-32){1'b0}}, acc_q[31:0]} : acc_q;
    div_sel   = op_q[1] ? r_raw : q_raw;
    div_sel_s = neg_q ? -div_sel : div_sel;
    div_res   = word_q ? {{(XLEN-32){div_sel_s[31]}}, div_sel_s[31:0]} : div_sel_s;

    if (fast_q)
      fix_res = lo_q;
    else if (op_q[2])
      fix_res = div_res;
    else
      fix_res = mul_res;
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q   <= op_i;
            word_q <= word_i;
            rd_q   <= rd_i;
            neg_q  <= neg_d;
            fast_q <= fast_d;
            cnt_q  <= word_i ? CW'(31) : CW'(XLEN-1);
            acc_q  <= '0;
            if (fast_d) begin
              lo_q    <= fast_res_d;
              b_q     <= '0;
              state_q <= S_FIXUP;
            end else begin
              if (op_i[2]) begin
                // W dividend sits in the top word so 32 shifts consume it.
                lo_q <= word_i ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                b_q  <= mag_b;
              end else begin
                lo_q <= mag_b;
                b_q  <= mag_a;
              end
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              acc_q <= div_acc_d;
              lo_q  <= div_lo_d;
            end else begin
              acc_q <= mul_acc_d;
              lo_q  <= mul_lo_d;
            end
            if (cnt_q == '0)
              state_q <= S_FIXUP;
            else
              cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIXUP: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_res;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
`timescale 1ns/1ps
module tb_muldiv_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic        word_i;
  logic [63:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        busy_o, done_o;
  logic [63:0] result_o;
  logic [4:0]  rd_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_seq_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .word_i(word_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one op, wait for done_o, and return one cycle later (back in IDLE).
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        output logic [63:0] res, output logic [4:0] rdo, output int lat);
    op_i = op; word_i = w; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
    res = '0; rdo = '0; lat = -1;
    cyc = 0;
    step();
    start_i = 1'b0;
    while (cyc < 200 && lat < 0) begin
      if (done_o) begin
        lat = cyc; res = result_o; rdo = rd_o;
      end else begin
        step();
      end
    end
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout op=%0d word=%0d: no done_o within 200 cycles", op, w);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; flush_i = 0; op_i = 0; word_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
    step(); step();
    n_cmp++;
    if ({busy_o, done_o, result_o, rd_o} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b res=%h rd=%0d, want all 0", busy_o, done_o, result_o, rd_o);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%0b want 0", busy_o); end
  endtask

  task automatic test_mul();
    logic [63:0] r; logic [4:0] t; int l;
    run_op(MUL, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, r, t, l);
    n_cmp++; if (r !== 64'd1) begin n_err++; $display("FAIL mul_m1: got %h want %h", r, 64'd1); end
    n_cmp++; if (l !== 66) begin n_err++; $display("FAIL mul_latency: got %0d want 66", l); end
    n_cmp++; if (t !== 5'd3) begin n_err++; $display("FAIL mul_rd: got %0d want 3", t); end
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: done=%0b busy=%0b want 0 0", done_o, busy_o); end
    run_op(MULH, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, r, t, l);
    n_cmp++; if (r !== 64'd0) begin n_err++; $display("FAIL mulh_m1: got %h want 0", r); end
    run_op(MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulhu_max: got %h want fffffffffffffffe", r); end
    run_op(MULHSU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL mulhsu_neg: got %h want ffffffffffffffff", r); end
  endtask

  task automatic test_div();
    logic [63:0] r; logic [4:0] t; int l;
    run_op(DIV, 0, -64'sd7, 64'd2, 5'd7, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_neg: got %h want fffffffffffffffd", r); end
    n_cmp++; if (l !== 66) begin n_err++; $display("FAIL div_latency: got %0d want 66", l); end
    run_op(REM, 0, -64'sd7, 64'd2, 5'd8, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rem_neg: got %h want ffffffffffffffff", r); end
    run_op(DIVU, 0, 64'd100, 64'd7, 5'd9, r, t, l);
    n_cmp++; if (r !== 64'd14) begin n_err++; $display("FAIL divu: got %h want e", r); end
    run_op(REMU, 0, 64'd100, 64'd7, 5'd10, r, t, l);
    n_cmp++; if (r !== 64'd2) begin n_err++; $display("FAIL remu: got %h want 2", r); end
  endtask

  task automatic test_fast_path();
    logic [63:0] r; logic [4:0] t; int l;
    run_op(DIVU, 0, 64'd5, 64'd0, 5'd11, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divu_by0: got %h want all ones", r); end
    n_cmp++; if (l !== 2) begin n_err++; $display("FAIL fast_latency: got %0d want 2", l); end
    n_cmp++; if (t !== 5'd11) begin n_err++; $display("FAIL fast_rd: got %0d want 11", t); end
    run_op(REMU, 0, 64'd5, 64'd0, 5'd12, r, t, l);
    n_cmp++; if (r !== 64'd5) begin n_err++; $display("FAIL remu_by0: got %h want 5", r); end
    run_op(REM, 0, -64'sd7, 64'd0, 5'd12, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFF9) begin n_err++; $display("FAIL rem_by0: got %h want fffffffffffffff9", r); end
    run_op(DIV, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, r, t, l);
    n_cmp++; if (r !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL div_ovf: got %h want 8000000000000000", r); end
    n_cmp++; if (l !== 2) begin n_err++; $display("FAIL ovf_latency: got %0d want 2", l); end
    run_op(REM, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, r, t, l);
    n_cmp++; if (r !== 64'd0) begin n_err++; $display("FAIL rem_ovf: got %h want 0", r); end
  endtask

  task automatic test_word();
    logic [63:0] r; logic [4:0] t; int l;
    run_op(MUL, 1, 64'hDEAD_0000_7FFF_FFFF, 64'd2, 5'd15, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulw: got %h want fffffffffffffffe", r); end
    n_cmp++; if (l !== 34) begin n_err++; $display("FAIL w_latency: got %0d want 34", l); end
    run_op(DIVU, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd16, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divuw_max: got %h want all ones", r); end
    run_op(DIVU, 1, 64'h0000_0000_8000_0000, 64'd1, 5'd16, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL divuw_sext: got %h want ffffffff80000000", r); end
    run_op(DIV, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd17, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL divw_neg: got %h want fffffffffffffffd", r); end
    run_op(REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd18, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL remw_neg: got %h want all ones", r); end
    run_op(DIV, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd19, r, t, l);
    n_cmp++; if (r !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL divw_ovf: got %h want ffffffff80000000", r); end
    run_op(MULH, 1, 64'd3, 64'd5, 5'd20, r, t, l);
    n_cmp++; if (r !== 64'd0 || l !== 2) begin n_err++; $display("FAIL mulhw_invalid: got %h lat %0d want 0 lat 2", r, l); end
  endtask

  // Previous op was MULHW -> result 0, rd 20.
  task automatic test_flush();
    logic [63:0] r; logic [4:0] t; int l; bit seen;
    op_i = MUL; word_i = 0; rs1_i = '1; rs2_i = '1; rd_i = 5'd9; start_i = 1;
    cyc = 0;
    step();
    start_i = 0;
    while (cyc < 10) step();
    flush_i = 1;
    step();
    flush_i = 0;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy: busy=%0b at cycle %0d want 0", busy_o, cyc); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_o) seen = 1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done: done seen=%0b want 0", seen); end
    n_cmp++; if (result_o !== 64'd0 || rd_o !== 5'd20) begin n_err++; $display("FAIL flush_hold: res=%h rd=%0d want 0 20", result_o, rd_o); end
    start_i = 1; flush_i = 1;
    step();
    start_i = 0; flush_i = 0;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_priority: busy=%0b want 0", busy_o); end
    run_op(MULHU, 0, 64'h8000_0000_0000_0000, 64'd4, 5'd21, r, t, l);
    n_cmp++; if (r !== 64'd2 || l !== 66) begin n_err++; $display("FAIL restart_mulhu: got %h lat %0d want 2 lat 66", r, l); end
  endtask

  task automatic test_back_to_back();
    int l; logic [63:0] r;
    op_i = DIVU; word_i = 0; rs1_i = 64'd100; rs2_i = 64'd7; rd_i = 5'd22; start_i = 1;
    cyc = 0; l = -1; r = '0;
    step();
    op_i = MUL; rs1_i = 64'd3; rs2_i = 64'd3; rd_i = 5'd1;
    while (cyc < 200 && l < 0) begin
      if (done_o) begin l = cyc; r = result_o; end
      else step();
    end
    start_i = 0;
    step();
    n_cmp++; if (r !== 64'd14 || l !== 66) begin n_err++; $display("FAIL start_ignored: got %h lat %0d want e lat 66", r, l); end
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    op_i = DIV; word_i = 0; rs1_i = -64'sd7; rs2_i = 64'd2; rd_i = 5'd23; start_i = 1;
    cyc = 0;
    step();
    start_i = 0;
    while (cyc < 20) step();
    rst = 1;
    #1;
    n_cmp++;
    if ({busy_o, done_o, result_o, rd_o} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%0b done=%0b res=%h rd=%0d want all 0", busy_o, done_o, result_o, rd_o);
    end
    step(); step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_o || busy_o) seen = 1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_quiet: activity seen=%0b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_word();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
